pow_to_num: RTL and testbench
=============================

# pow_to_num

Sequential exponent-to-value decoder: it accepts a bit-position exponent `pow` and returns `num = 1 << pow` as a one-hot word. It is the inverse of the team's combinational one-hot-to-exponent encoder (`get_pow`), so `get_pow(pow_to_num(p)) == p` for every legal `p`. It builds the result with one left shift per cycle. Handshakes are valid/ready on both sides, and one transaction is in flight at a time. It sits between exponent-producing control logic and datapaths that need one-hot bit masks.

## Interface
Parameters:
- `W_POW`, default 3: exponent width.
- `W_NUM`, default `1 << W_POW` (8): result width. Do not override independently.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: `pow` is valid.
- `in_ready`, output, 1: block can accept an exponent; high only in IDLE.
- `pow`, input, `W_POW`: exponent, unsigned, 0 to `W_NUM-1`.
- `out_valid`, output, 1: `num` holds a completed result; high only in DONE.
- `out_ready`, input, 1: consumer accepts the result.
- `num`, output, `W_NUM`: working/result register.
- `busy`, output, 1: high in SHIFT or DONE.

## Operation
States:
- IDLE
  - `in_ready` = 1.
  - Accept occurs on an edge with `in_valid & in_ready`.
  - On accept: `num <= 1`, `cnt <= pow`.
  - Next state is DONE if `pow == 0`, else SHIFT.
- SHIFT
  - Each edge: `num <= num << 1`, `cnt <= cnt - 1`.
  - When `cnt == 1` at the edge, next state is DONE.
- DONE
  - `out_valid` = 1; `num` is held stable.
  - On an edge with `out_ready = 1`: go to IDLE.
  - `num` keeps the last result after the transfer.

Arithmetic rules:
- `cnt` is `W_POW` bits wide.
- `pow` is always in range, so `num` never overflows; exactly one bit of `num` is set from accept until the next reset.

Handshake rules:
- `pow` is sampled only on the accept edge. Later changes to `pow` or `in_valid` do not affect the transaction in flight.
- `in_valid` while busy is not accepted and is not queued. The producer must hold it until `in_ready` is high.
- `in_ready` and `out_valid` are decoded from registered state; there are no combinational input-to-output paths.
- No simultaneous accept and output: the DONE→IDLE transfer edge cannot also accept. The next accept is possible on the following edge.

Reset:
- `rst_n` low at any edge, from any state including mid-SHIFT: state becomes IDLE, `num` = 0, `cnt` = 0.
- The in-flight result is discarded and nothing is emitted.
- `in_valid` is ignored on edges where `rst_n` is low.

Reset values:
- `in_ready` = 1 in the cycle after the reset edge (IDLE).
- `out_valid` = 0.
- `busy` = 0.
- `num` = 0.

## Timing
- Let the accept edge be edge k. `out_valid` is first high in the cycle after edge `k + pow`.
  - `pow = 0`: `out_valid` high immediately after edge k.
  - `pow = 7`: 7 SHIFT edges, then `out_valid`.
- During SHIFT, `num` after edge `k+i` equals `1 << i`.
- Throughput: one transaction per `pow + 2` cycles when `out_ready` is held high (accept edge, `pow` shifts, transfer edge).
- Backpressure: DONE is held indefinitely while `out_ready` = 0. `num` and `out_valid` do not change.
- `out_ready` in IDLE or SHIFT is ignored.

## Test plan
- Reset, then `pow = 0` accepted with `out_ready` = 1: `num` = 0x01 and `out_valid` = 1 in the cycle after the accept edge; back in IDLE one edge later.
- `pow = 7` accepted: `busy` high; `num` steps 0x01→0x02→…→0x80 over 7 edges; then `out_valid` = 1 with `num` = 0x80.
- `pow = 6`, `out_ready` held low for 5 cycles in DONE: `num` stays 0x40 and `out_valid` stays 1; transfer on the first `out_ready` = 1 edge.
- `in_valid` held high continuously with `pow` = 5 while busy: exactly one accept per transaction; `in_ready` = 0 throughout SHIFT and DONE.
- Sweep `pow` 0..7 back-to-back with random `out_ready`: each result equals `1 << pow`, feeding `num` into `get_pow` returns the original `pow`, and no transaction is lost or duplicated.
- `pow = 7` accepted, `rst_n` driven low at the third SHIFT edge: next cycle shows IDLE, `num` = 0, `out_valid` = 0, `in_ready` = 1; no result is emitted.

Source files
------------

// File: rtl/pow_to_num.sv
// Sequential exponent-to-one-hot decoder: returns num = 1 << pow, built with one
// left shift per cycle behind valid/ready handshakes on both sides.
module pow_to_num #(
    parameter int W_POW = 3,
    parameter int W_NUM = 1 << W_POW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_POW-1:0] pow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_NUM-1:0] num,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W_POW-1:0] r_cnt;
    logic [W_NUM-1:0] r_num;
    logic             w_accept;

    assign w_accept = (r_state == IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_num <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_num <= W_NUM'(1);
                        r_cnt <= pow;
                    end
                end
                SHIFT: begin
                    r_num <= r_num << 1;
                    r_cnt <= r_cnt - W_POW'(1);
                end
                default: begin
                    r_num <= r_num;
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (pow == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == W_POW'(1)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs depend only on registered state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE:    in_ready = 1'b1;
            SHIFT:   busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign num = r_num;

endmodule

// File: tb/tb_pow_to_num.sv
// Directed bench for pow_to_num: vector table plus handshake, backpressure and
// mid-shift reset sequences.
module tb_pow_to_num;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] pow;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] num;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    pow_to_num #(.W_POW(3), .W_NUM(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pow      (pow),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .num      (num),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] p;
        int         hold;
        logic [7:0] exp_num;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int get_pow(input logic [7:0] v);
        int idx = -1;
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = i;
                ones++;
            end
        end
        return (ones == 1) ? idx : -1;
    endfunction

    // Accept p, follow the shift sequence, hold DONE for `hold` cycles, then transfer.
    task automatic run_txn(input logic [2:0] p, input int hold, input logic [7:0] exp_num);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        pow      = p;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        pow      = ~p;
        for (int i = 0; i <= int'(p); i++) begin
            check("shift_num", 32'(num), 32'(8'd1 << i));
            check("shift_out_valid", 32'(out_valid), 32'(i == int'(p)));
            check("shift_busy", 32'(busy), 32'd1);
            check("shift_in_ready", 32'(in_ready), 32'd0);
            if (i < int'(p)) @(negedge clk);
        end
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_num", 32'(num), 32'(exp_num));
        end
        check("result_num", 32'(num), 32'(exp_num));
        check("get_pow", 32'(get_pow(num)), 32'(p));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_xfer_out_valid", 32'(out_valid), 32'd0);
        check("post_xfer_in_ready", 32'(in_ready), 32'd1);
        check("post_xfer_num", 32'(num), 32'(exp_num));
    endtask

    initial begin
        int accepts;
        int xfers;
        int got;
        int seen_valid;
        bit done_one;
        logic r;

        vecs[0] = '{3'd0, 0, 8'h01};
        vecs[1] = '{3'd7, 0, 8'h80};
        vecs[2] = '{3'd6, 5, 8'h40};
        vecs[3] = '{3'd3, 1, 8'h08};
        vecs[4] = '{3'd1, 0, 8'h02};
        vecs[5] = '{3'd2, 2, 8'h04};
        vecs[6] = '{3'd4, 0, 8'h10};
        vecs[7] = '{3'd5, 3, 8'h20};

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        pow       = 3'd3;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_num", 32'(num), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].p, vecs[v].hold, vecs[v].exp_num);
        end

        // in_valid held high with pow=5: one accept per 7-cycle transaction
        accepts   = 0;
        xfers     = 0;
        pow       = 3'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 21; c++) begin
            if (in_ready) accepts++;
            if (out_valid) begin
                xfers++;
                check("stream_num", 32'(num), 32'h20);
            end
            if (busy) check("stream_in_ready_busy", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_accepts", 32'(accepts), 32'd3);
        check("stream_xfers", 32'(xfers), 32'd3);
        @(negedge clk);

        // Sweep 0..7 with random out_ready
        got = 0;
        for (int p = 0; p < 8; p++) begin
            check("sweep_in_ready", 32'(in_ready), 32'd1);
            pow      = 3'(p);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            done_one = 1'b0;
            for (int c = 0; c < 60 && !done_one; c++) begin
                r = 1'($urandom_range(0, 1));
                out_ready = r;
                if (out_valid && r) begin
                    got++;
                    done_one = 1'b1;
                    check("sweep_num", 32'(num), 32'(8'd1 << p));
                    check("sweep_get_pow", 32'(get_pow(num)), 32'(p));
                end
                @(negedge clk);
            end
            out_ready = 1'b0;
            if (!done_one) check("sweep_timeout", 32'd1, 32'd0);
        end
        check("sweep_count", 32'(got), 32'd8);

        // Reset at the third SHIFT edge of a pow=7 transaction
        pow      = 3'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("abort_num_k", 32'(num), 32'h01);
        @(negedge clk);
        @(negedge clk);
        check("abort_num_k2", 32'(num), 32'h04);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_num", 32'(num), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        seen_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        out_ready = 1'b0;
        check("abort_no_emit", 32'(seen_valid), 32'd0);
        run_txn(3'd2, 1, 8'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
